// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared combinational MIPS alu: grant, execute, hold result.
// Build option: define ALU_ARB_RR_EN for round-robin ties; default is fixed priority to port 0.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_0,
    input  logic                  req_valid_1,
    output logic                  req_ready_0,
    output logic                  req_ready_1,
    input  logic [DATA_WIDTH-1:0] req_a_0,
    input  logic [DATA_WIDTH-1:0] req_a_1,
    input  logic [DATA_WIDTH-1:0] req_b_0,
    input  logic [DATA_WIDTH-1:0] req_b_1,
    input  logic [2:0]            req_op_0,
    input  logic [2:0]            req_op_1,
    output logic                  rsp_valid_0,
    output logic                  rsp_valid_1,
    input  logic                  rsp_ready_0,
    input  logic                  rsp_ready_1,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic [2:0]            rsp_flags,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_overflow,
    input  logic                  alu_carryout,
    input  logic                  alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [2:0]            flags_q, flags_d;
    logic                  grant1;
    logic                  idle_grant;
    logic                  rsp_fire;

`ifdef ALU_ARB_RR_EN
    logic ptr_q, ptr_d;

    // Tie goes to the port that did not win last time.
    always_comb begin
        grant1 = req_valid_1;
        if (req_valid_0 && req_valid_1) begin
            grant1 = ~ptr_q;
        end
    end
`else
    always_comb begin
        grant1 = req_valid_1 & ~req_valid_0;
    end
`endif

    // No grant while reset is held: the latched operands would be discarded.
    assign idle_grant  = (state_q == S_IDLE) && !rst
                         && (req_valid_0 || req_valid_1);
    assign req_ready_0 = idle_grant && !grant1;
    assign req_ready_1 = idle_grant && grant1;

    assign rsp_valid_0 = (state_q == S_RESP) && !owner_q;
    assign rsp_valid_1 = (state_q == S_RESP) && owner_q;
    assign rsp_fire    = owner_q ? rsp_ready_1 : rsp_ready_0;
    assign rsp_result  = result_q;
    assign rsp_flags   = flags_q;

    assign alu_a  = (state_q == S_EXEC) ? a_q : '0;
    assign alu_b  = (state_q == S_EXEC) ? b_q : '0;
    assign alu_op = (state_q == S_EXEC) ? op_q : 3'b000;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef ALU_ARB_RR_EN
        ptr_d    = ptr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (idle_grant) begin
                    owner_d = grant1;
                    a_d     = grant1 ? req_a_1 : req_a_0;
                    b_d     = grant1 ? req_b_1 : req_b_0;
                    op_d    = grant1 ? req_op_1 : req_op_0;
`ifdef ALU_ARB_RR_EN
                    ptr_d   = grant1;
`endif
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = alu_result;
                flags_d  = {alu_overflow, alu_carryout, alu_zero};
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (rsp_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'b000;
            result_q <= '0;
            flags_q  <= 3'b000;
`ifdef ALU_ARB_RR_EN
            ptr_q    <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            flags_q  <= flags_d;
`ifdef ALU_ARB_RR_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural MIPS alu attached to its alu_* ports.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic [2:0]  req_op_0, req_op_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic        rsp_ready_0, rsp_ready_1;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flags;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_overflow, alu_carryout, alu_zero;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .alu_carryout(alu_carryout), .alu_zero(alu_zero)
    );

    // CarryOut for SUB is the carry out of a + ~b + 1.
    logic [32:0] sum;
    always_comb begin
        sum          = 33'd0;
        alu_result   = 32'd0;
        alu_overflow = 1'b0;
        alu_carryout = 1'b0;
        case (alu_op)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010: begin
                sum          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = sum[31:0];
                alu_carryout = sum[32];
                alu_overflow = (alu_a[31] == alu_b[31])
                               && (sum[31] != alu_a[31]);
            end
            3'b110: begin
                sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_result   = sum[31:0];
                alu_carryout = sum[32];
                alu_overflow = (alu_a[31] != alu_b[31])
                               && (sum[31] != alu_a[31]);
            end
            3'b111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int p, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] er, input logic [2:0] ef);
        if (p == 0) begin
            req_valid_0 = 1'b1; req_a_0 = a; req_b_0 = b; req_op_0 = op;
        end else begin
            req_valid_1 = 1'b1; req_a_1 = a; req_b_1 = b; req_op_1 = op;
        end
        rsp_ready_0 = 1'b1;
        rsp_ready_1 = 1'b1;
        #1;
        chk("op_req_ready_own", p ? req_ready_1 : req_ready_0, 1);
        chk("op_req_ready_oth", p ? req_ready_0 : req_ready_1, 0);
        step();
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        #1;
        chk("op_exec_alu_a", alu_a, a);
        chk("op_exec_alu_b", alu_b, b);
        chk("op_exec_alu_op", alu_op, op);
        chk("op_exec_no_rsp", rsp_valid_0 | rsp_valid_1, 0);
        step();
        chk("op_rsp_valid_own", p ? rsp_valid_1 : rsp_valid_0, 1);
        chk("op_rsp_valid_oth", p ? rsp_valid_0 : rsp_valid_1, 0);
        chk("op_rsp_result", rsp_result, er);
        chk("op_rsp_flags", rsp_flags, ef);
        chk("op_rsp_alu_idle", alu_a, 0);
        step();
        chk("op_idle_rsp_valid", rsp_valid_0 | rsp_valid_1, 0);
        chk("op_idle_result_kept", rsp_result, er);
    endtask

    int          rem0, rem1, ng, nr;
    int          gseq [6];
    int          exp_seq [6];
    int          last_g;
    logic [31:0] exp_res;

    initial begin
        rst = 1'b1;
        req_valid_0 = 0; req_valid_1 = 0;
        req_a_0 = 0; req_a_1 = 0; req_b_0 = 0; req_b_1 = 0;
        req_op_0 = 0; req_op_1 = 0;
        rsp_ready_0 = 0; rsp_ready_1 = 0;
        step();
        step();
        chk("rst_req_ready", {req_ready_1, req_ready_0}, 0);
        chk("rst_rsp_valid", {rsp_valid_1, rsp_valid_0}, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_flags", rsp_flags, 0);
        chk("rst_alu", {alu_a | alu_b, 29'd0, alu_op}, 0);
        rst = 1'b0;
        step();

        do_op(0, 32'd5, 32'd7, 3'b010, 32'd12, 3'b000);
        do_op(1, 32'd3, 32'd3, 3'b110, 32'd0, 3'b011);
        do_op(0, 32'h7FFF_FFFF, 32'd1, 3'b010, 32'h8000_0000, 3'b100);
        do_op(1, 32'h0F0F_00FF, 32'h00FF_0F0F, 3'b000, 32'h000F_000F, 3'b000);

        // Contention: both ports valid from reset, three ops each.
        rst = 1'b1;
        step();
        rst = 1'b0;
        rem0 = 3; rem1 = 3; ng = 0; nr = 0; last_g = 0; exp_res = 0;
        rsp_ready_0 = 1'b1;
        rsp_ready_1 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            req_valid_0 = rem0 > 0;
            req_valid_1 = rem1 > 0;
            req_a_0 = 32'd10 + 32'(3 - rem0); req_b_0 = 32'd1;
            req_a_1 = 32'd100 + 32'(3 - rem1); req_b_1 = 32'd1;
            req_op_0 = 3'b010; req_op_1 = 3'b010;
            #1;
            if (rsp_valid_0 || rsp_valid_1) begin
                chk("cont_rsp_owner", {31'd0, rsp_valid_1}, last_g);
                chk("cont_rsp_result", rsp_result, exp_res);
                nr++;
            end
            if (req_ready_0 && ng < 6) begin
                gseq[ng] = 0; ng++; rem0--; last_g = 0;
                exp_res = req_a_0 + 32'd1;
            end
            if (req_ready_1 && ng < 6) begin
                gseq[ng] = 1; ng++; rem1--; last_g = 1;
                exp_res = req_a_1 + 32'd1;
            end
            step();
        end
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        chk("cont_grants", ng, 6);
        chk("cont_rsps", nr, 6);
`ifdef ALU_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 1, 1, 1};
`endif
        for (int i = 0; i < 6; i++) begin
            if (i < ng) chk($sformatf("cont_seq%0d", i), gseq[i], exp_seq[i]);
        end

        // Backpressure on port 0; non-owner rsp_ready and valid must be ignored.
        req_valid_0 = 1'b1; req_a_0 = 32'd20; req_b_0 = 32'd22;
        req_op_0 = 3'b010;
        rsp_ready_0 = 1'b0;
        rsp_ready_1 = 1'b1;
        #1;
        chk("bp_grant", req_ready_0, 1);
        step();
        req_valid_1 = 1'b1;
        step();
        chk("bp_rsp_valid", rsp_valid_0, 1);
        chk("bp_result", rsp_result, 32'd42);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold_valid", {rsp_valid_1, rsp_valid_0}, 2'b01);
            chk("bp_hold_result", rsp_result, 32'd42);
            chk("bp_hold_flags", rsp_flags, 0);
            chk("bp_req_ready", {req_ready_1, req_ready_0}, 0);
        end
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        rsp_ready_0 = 1'b1;
        step();
        chk("bp_done", {rsp_valid_1, rsp_valid_0}, 0);
        chk("bp_kept_result", rsp_result, 32'd42);

        // Reset during EXEC aborts the transaction.
        req_valid_0 = 1'b1; req_a_0 = 32'd1; req_b_0 = 32'd2;
        #1;
        chk("rx_grant", req_ready_0, 1);
        step();
        req_valid_0 = 1'b0;
        rst = 1'b1;
        #1;
        chk("rx_exec_alu_a", alu_a, 32'd1);
        step();
        rst = 1'b0;
        chk("rx_rsp_valid", {rsp_valid_1, rsp_valid_0}, 0);
        chk("rx_result", rsp_result, 0);
        chk("rx_flags", rsp_flags, 0);
        chk("rx_alu", alu_a | alu_b, 0);
        chk("rx_req_ready", {req_ready_1, req_ready_0}, 0);
        step();
        chk("rx_no_late_rsp", {rsp_valid_1, rsp_valid_0}, 0);
        do_op(0, 32'd9, 32'd4, 3'b010, 32'd13, 3'b000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` instance of the multi-cycle MIPS core between two requesters, for example the main control FSM (PC/branch/address arithmetic) and an iterative helper unit. The block arbitrates, registers operands, sequences one ALU evaluation and holds the result and flags until the owning requester accepts them. It sits between the requesters and the `alu` ports `A/B/ALUop/Result/Overflow/CarryOut/Zero`.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand and result width; must match the `alu` instance.

Ports. Clock is `clk`; reset is `rst`, synchronous and active-high:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid_0` / `req_valid_1`  in  1  each: request pending on port 0 / 1.
- `req_ready_0` / `req_ready_1`  out  1  each: request accepted this cycle.
- `req_a_0` / `req_a_1`, `req_b_0` / `req_b_1`  in  DATA_WIDTH  each: operands.
- `req_op_0` / `req_op_1`  in  3  each: ALUop encoding, passed through unchanged.
- `rsp_valid_0` / `rsp_valid_1`  out  1  each: result available for port 0 / 1.
- `rsp_ready_0` / `rsp_ready_1`  in  1  each: requester consumes the result.
- `rsp_result`  out  DATA_WIDTH  registered result, shared by both ports.
- `rsp_flags`  out  3  registered `{Overflow, CarryOut, Zero}`, shared by both ports.
- `alu_a`, `alu_b`  out  DATA_WIDTH  drive `alu.A` and `alu.B`.
- `alu_op`  out  3  drives `alu.ALUop`.
- `alu_result`  in  DATA_WIDTH  from `alu.Result`.
- `alu_overflow`, `alu_carryout`, `alu_zero`  in  1  each: from the `alu` flags.

## Operation
- The FSM has three states:
  - IDLE. If any `req_valid_x` is high, grant exactly one port. Assert its `req_ready_x` combinationally in that cycle. Latch `a/b/op` into operand registers and latch the owner ID. Go to EXEC.
  - EXEC. Drive `alu_a/alu_b/alu_op` from the operand registers. On the clock edge, capture `alu_result` and the three flags into `rsp_result/rsp_flags`. Go to RESP.
  - RESP. Assert `rsp_valid_<owner>` only; the other port's `rsp_valid` stays 0. On `rsp_valid && rsp_ready`, go to IDLE.
- Arbitration with both ports valid in IDLE is set by `ALU_ARB_RR_EN` (see Configuration).
- `req_ready_x` is 0 in EXEC and in RESP. Only one operation is outstanding at a time.
- In IDLE and RESP, `alu_a`, `alu_b` and `alu_op` are driven to 0.
- Operands and op are used bit-for-bit; the block performs no arithmetic or width conversion.
- `rsp_result` and `rsp_flags` stay stable from entry into RESP until the handshake. They keep their last value in IDLE.
- A requester may drop `req_valid` before it is granted; nothing is latched in that case.
- Reset values: state = IDLE, every `req_ready` = 0, every `rsp_valid` = 0, `rsp_result` = 0, `rsp_flags` = 0, `alu_*` = 0, owner = 0, last-grant pointer = 1 (so port 0 wins the first tie).
- Reset mid-operation (EXEC or RESP) aborts the transaction. No `rsp_valid` is produced for it, and the requester must reissue.

## Timing
- Request handshake in cycle T, with the FSM in IDLE.
- EXEC is cycle T+1.
- `rsp_valid` rises in cycle T+2 and holds until `rsp_ready` is sampled high.
- If `rsp_ready` is already high at T+2, the FSM is in IDLE at T+3, and a new grant can happen in T+3.
- Peak throughput is one operation per 3 cycles.
- The owner may assert `rsp_ready` early; it has effect only in RESP.
- `rsp_ready` from the non-owner is ignored.
- `req_ready` depends combinationally on `req_valid` in IDLE. All other outputs are registered or driven from registers.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - When both ports are valid in IDLE, grant the port that is not the last-grant pointer.
  - The pointer updates to the granted port on every grant.
  - A single valid port is always granted.
- `ALU_ARB_RR_EN` undefined: fixed priority, port 0 always wins ties. The last-grant pointer is not implemented.

## Test plan
- ADD, single port: port 0 requests `a=5, b=7, op=010` with `rsp_ready_0` held high. Handshake at T; `rsp_valid_0=1` at T+2 with `rsp_result=12`, `rsp_flags=000`; `rsp_valid_1=0` throughout.
- SUB to zero, port 1: `a=3, b=3, op=110`. `rsp_result=0`, Zero flag = 1.
- Overflow: `a=0x7FFFFFFF, b=1, op=010`. `rsp_result=0x80000000`, Overflow flag = 1.
- Contention: both ports valid continuously after reset with 3 operations each.
  - With the macro: grants go 0,1,0,1,0,1.
  - Without the macro: 0,0,0 first, then 1,1,1.
- Backpressure: hold `rsp_ready_0=0` for 4 cycles in RESP. `rsp_valid_0`, `rsp_result` and `rsp_flags` stay stable; `req_ready_0/1` stay 0. Completion follows the cycle after `rsp_ready_0` rises.
- Reset mid-EXEC: assert `rst` in T+1. No `rsp_valid` appears; all outputs are at reset values in the following cycle; the next request then completes normally.
